// File: rtl/endpoint_flit_injector_if.sv
// ---------------------------------------------------------------------------
// endpoint_flit_injector_if
// Groups the handshake and router-channel signals of the endpoint flit
// injector.
//   req_*      : packet request (valid/ready, dest, len, vc) from the core
//   data_*     : body payload stream (valid/ready, data_in) from the core
//   flit_out   : {hdr, tail, payload} towards the router local input port
//   flit_wr    : flit valid strobe
//   flit_vc    : one-hot VC of the current flit
//   credit_in  : per-VC credit return pulses from the router
// modport master : the injector (drives ready signals and the flit channel)
// modport slave  : the core/router environment around the injector
// ---------------------------------------------------------------------------
interface endpoint_flit_injector_if #(
    parameter int unsigned V    = 2,
    parameter int unsigned EAw  = 4,
    parameter int unsigned LENw = 4,
    parameter int unsigned PYw  = 32
);
    localparam int unsigned Vw = (V > 1) ? $clog2(V) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [EAw-1:0]    req_dest;
    logic [LENw-1:0]   req_len;
    logic [Vw-1:0]     req_vc;

    logic              data_valid;
    logic              data_ready;
    logic [PYw-1:0]    data_in;

    logic [PYw+1:0]    flit_out;
    logic              flit_wr;
    logic [V-1:0]      flit_vc;
    logic [V-1:0]      credit_in;

    modport master (
        input  req_valid, req_dest, req_len, req_vc,
        output req_ready,
        input  data_valid, data_in,
        output data_ready,
        output flit_out, flit_wr, flit_vc,
        input  credit_in
    );

    modport slave (
        output req_valid, req_dest, req_len, req_vc,
        input  req_ready,
        output data_valid, data_in,
        input  data_ready,
        input  flit_out, flit_wr, flit_vc,
        output credit_in
    );
endinterface

// File: rtl/endpoint_flit_injector.sv
// ---------------------------------------------------------------------------
// endpoint_flit_injector
// Endpoint-side transmitter for the NoC local port. Accepts a packet request,
// emits a header flit, then one body flit per accepted payload word; the last
// flit carries tail=1. Per-VC credit counters (initialised to B) gate every
// flit; credits are returned by the router through credit_in.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset
//   bus        : endpoint_flit_injector_if.master (request, data, flit, credits)
//   busy       : packet in progress (HEAD or BODY)
//   credit_err : sticky, a credit was returned to a VC already holding B
// ---------------------------------------------------------------------------
module endpoint_flit_injector #(
    parameter int unsigned V        = 2,
    parameter int unsigned B        = 4,
    parameter int unsigned EAw      = 4,
    parameter int unsigned SRC_ADDR = 0,
    parameter int unsigned LENw     = 4,
    parameter int unsigned PYw      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    endpoint_flit_injector_if.master  bus,
    output logic                      busy,
    output logic                      credit_err
);
    localparam int unsigned Vw = (V > 1) ? $clog2(V) : 1;
    localparam int unsigned CW = $clog2(B + 1);
    localparam logic [CW-1:0]  CRED_MAX = CW'(B);
    localparam logic [EAw-1:0] SRC      = EAw'(SRC_ADDR);

    if (PYw < 2 * EAw + LENw) begin : g_pyw_check
        $error("endpoint_flit_injector: PYw must be >= 2*EAw+LENw");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY
    } state_t;

    state_t           state_q, state_d;
    logic [EAw-1:0]   dest_q, dest_d;
    logic [LENw-1:0]  len_q, len_d;
    logic [LENw-1:0]  rem_q, rem_d;
    logic [Vw-1:0]    vc_q, vc_d;
    logic [PYw+1:0]   flit_out_q, flit_out_d;
    logic             flit_wr_q, flit_wr_d;
    logic [V-1:0]     flit_vc_q, flit_vc_d;
    logic             req_ready_q, req_ready_d;
    logic             credit_err_q, credit_err_d;
    logic [CW-1:0]    credit_q [V];
    logic [CW-1:0]    credit_d [V];

    logic [V-1:0]     vc_onehot;
    logic [V-1:0]     cred_nz;
    logic             cred_avail;
    logic             send;
    logic [PYw-1:0]   hdr_payload;

    // Credit availability is selected through the one-hot mask so that an
    // out-of-range VC index can never address a non-existent counter.
    always_comb begin
        vc_onehot = V'(1) << vc_q;
        for (int unsigned v = 0; v < V; v++) begin
            cred_nz[v] = (credit_q[v] != '0);
        end
        cred_avail  = |(cred_nz & vc_onehot);
        hdr_payload = PYw'({len_q, SRC, dest_q});
    end

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        len_d        = len_q;
        rem_d        = rem_q;
        vc_d         = vc_q;
        flit_out_d   = flit_out_q;
        flit_wr_d    = 1'b0;
        flit_vc_d    = '0;
        credit_err_d = credit_err_q;
        send         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    dest_d  = bus.req_dest;
                    len_d   = (bus.req_len == '0) ? LENw'(1) : bus.req_len;
                    vc_d    = bus.req_vc;
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (cred_avail) begin
                    send       = 1'b1;
                    flit_wr_d  = 1'b1;
                    flit_vc_d  = vc_onehot;
                    flit_out_d = {1'b1, (len_q == LENw'(1)), hdr_payload};
                    rem_d      = len_q - LENw'(1);
                    state_d    = (len_q == LENw'(1)) ? S_IDLE : S_BODY;
                end
            end
            S_BODY: begin
                if (bus.data_valid && cred_avail) begin
                    send       = 1'b1;
                    flit_wr_d  = 1'b1;
                    flit_vc_d  = vc_onehot;
                    flit_out_d = {1'b0, (rem_q == LENw'(1)), bus.data_in};
                    rem_d      = rem_q - LENw'(1);
                    if (rem_q == LENw'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered ready: high in every cycle the FSM sits in IDLE.
        req_ready_d = (state_d == S_IDLE);

        // A send and a return on the same VC in one cycle cancel out; a
        // lone return on a full counter is dropped and flagged.
        for (int unsigned v = 0; v < V; v++) begin
            credit_d[v] = credit_q[v];
            if (send && vc_onehot[v] && !bus.credit_in[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (!(send && vc_onehot[v]) && bus.credit_in[v]) begin
                if (credit_q[v] == CRED_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            dest_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            vc_q         <= '0;
            flit_out_q   <= '0;
            flit_wr_q    <= 1'b0;
            flit_vc_q    <= '0;
            req_ready_q  <= 1'b0;
            credit_err_q <= 1'b0;
            for (int unsigned v = 0; v < V; v++) begin
                credit_q[v] <= CRED_MAX;
            end
        end else begin
            state_q      <= state_d;
            dest_q       <= dest_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            vc_q         <= vc_d;
            flit_out_q   <= flit_out_d;
            flit_wr_q    <= flit_wr_d;
            flit_vc_q    <= flit_vc_d;
            req_ready_q  <= req_ready_d;
            credit_err_q <= credit_err_d;
            for (int unsigned v = 0; v < V; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.data_ready = (state_q == S_BODY) && cred_avail;
    assign bus.flit_out   = flit_out_q;
    assign bus.flit_wr    = flit_wr_q;
    assign bus.flit_vc    = flit_vc_q;
    assign busy           = (state_q != S_IDLE);
    assign credit_err     = credit_err_q;
endmodule

// File: tb/tb_endpoint_flit_injector.sv
// ---------------------------------------------------------------------------
// tb_endpoint_flit_injector
// Directed scenarios followed by randomized traffic. A packet-level model
// (credit counts, header/body bookkeeping) predicts every cycle's outputs.
// ---------------------------------------------------------------------------
module tb_endpoint_flit_injector;
    localparam int unsigned V        = 2;
    localparam int unsigned B        = 4;
    localparam int unsigned EAw      = 4;
    localparam int unsigned SRC_ADDR = 9;
    localparam int unsigned LENw     = 4;
    localparam int unsigned PYw      = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic busy;
    logic credit_err;

    endpoint_flit_injector_if #(.V(V), .EAw(EAw), .LENw(LENw), .PYw(PYw)) bus ();

    endpoint_flit_injector #(
        .V(V), .B(B), .EAw(EAw), .SRC_ADDR(SRC_ADDR), .LENw(LENw), .PYw(PYw)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             mcred [V];
    bit             merr;
    bit             pk_act, hdr_pend;
    int             pk_len, pk_dest, pk_vc, body_left;
    bit             exp_wr;
    logic [PYw+1:0] exp_flit;
    logic [V-1:0]   exp_vc;
    int             nedge;

    always @(negedge clk) begin
        bit exp_rr, exp_dr, send_hdr, body_hs, acc, dec, inc;
        if (!reset) begin
            for (int v = 0; v < V; v++) mcred[v] = B;
            merr = 0; pk_act = 0; hdr_pend = 0; body_left = 0;
            pk_len = 0; pk_dest = 0; pk_vc = 0;
            exp_wr = 0; exp_flit = '0; exp_vc = '0; nedge = 0;
        end else begin
            exp_rr = !pk_act && (nedge > 0);
            exp_dr = pk_act && !hdr_pend && (mcred[pk_vc] > 0);
            chk("m_flit_wr", bus.flit_wr, exp_wr);
            if (exp_wr) begin
                chk("m_flit_out", bus.flit_out, exp_flit);
                chk("m_flit_vc", bus.flit_vc, exp_vc);
            end else begin
                chk("m_flit_vc_idle", bus.flit_vc, 0);
            end
            chk("m_busy", busy, pk_act);
            chk("m_credit_err", credit_err, merr);
            chk("m_req_ready", bus.req_ready, exp_rr);
            chk("m_data_ready", bus.data_ready, exp_dr);

            send_hdr = pk_act && hdr_pend && (mcred[pk_vc] > 0);
            body_hs  = exp_dr && bus.data_valid;
            acc      = exp_rr && bus.req_valid;
            exp_wr   = send_hdr || body_hs;
            exp_vc   = exp_wr ? (V'(1) << pk_vc) : '0;
            if (send_hdr)
                exp_flit = {1'b1, pk_len == 1,
                            PYw'(pk_len * (1 << (2 * EAw)) + SRC_ADDR * (1 << EAw) + pk_dest)};
            else if (body_hs)
                exp_flit = {1'b0, body_left == 1, bus.data_in};
            for (int v = 0; v < V; v++) begin
                dec = exp_wr && (v == pk_vc);
                inc = bus.credit_in[v];
                if (dec && !inc) mcred[v]--;
                else if (inc && !dec) begin
                    if (mcred[v] == B) merr = 1;
                    else mcred[v]++;
                end
            end
            if (send_hdr) begin
                hdr_pend  = 0;
                body_left = pk_len - 1;
                if (pk_len == 1) pk_act = 0;
            end else if (body_hs) begin
                body_left--;
                if (body_left == 0) pk_act = 0;
            end
            if (acc) begin
                pk_act   = 1;
                hdr_pend = 1;
                pk_dest  = int'(bus.req_dest);
                pk_len   = (bus.req_len == 0) ? 1 : int'(bus.req_len);
                pk_vc    = int'(bus.req_vc);
            end
            nedge++;
        end
    end

    // ---------------- flit capture ----------------
    logic [PYw+1:0] cap_f [$];
    logic [V-1:0]   cap_v [$];

    always @(negedge clk) begin
        if (reset && bus.flit_wr) begin
            cap_f.push_back(bus.flit_out);
            cap_v.push_back(bus.flit_vc);
        end
    end

    // ---------------- stimulus ----------------
    bit req_hs, data_hs;

    task automatic tick();
        @(negedge clk);
        req_hs  = bus.req_valid && bus.req_ready;
        data_hs = bus.data_valid && bus.data_ready;
        @(posedge clk);
        #1;
        bus.credit_in = '0;
    endtask

    task automatic clear_cap();
        cap_f.delete();
        cap_v.delete();
    endtask

    task automatic chk_cap(input string name, input int idx,
                           input logic [PYw+1:0] f, input logic [V-1:0] v);
        if (idx < cap_f.size()) begin
            chk({name, "_flit"}, cap_f[idx], f);
            chk({name, "_vc"}, cap_v[idx], v);
        end else begin
            chk({name, "_missing"}, cap_f.size(), idx + 1);
        end
    endtask

    task automatic send_req(input int dest, input int len, input int vc);
        bus.req_valid = 1'b1;
        bus.req_dest  = EAw'(dest);
        bus.req_len   = LENw'(len);
        bus.req_vc    = 1'(vc);
        req_hs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (req_hs) break;
        end
        chk("req_accept", req_hs, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic feed(input logic [PYw-1:0] w, output int n);
        bus.data_valid = 1'b1;
        bus.data_in    = w;
        data_hs = 0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (data_hs) break;
        end
        chk("data_accept", data_hs, 1);
        bus.data_valid = 1'b0;
    endtask

    task automatic wait_flits(input int n);
        for (int i = 0; i < 50; i++) begin
            if (cap_f.size() >= n) break;
            tick();
        end
        chk("flit_count", cap_f.size(), n);
    endtask

    task automatic restore();
        for (int i = 0; i < 40; i++) begin
            bit full;
            full = 1;
            for (int v = 0; v < V; v++) begin
                if (mcred[v] < B) begin
                    bus.credit_in[v] = 1'b1;
                    full = 0;
                end
            end
            if (full) break;
            tick();
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_dest   = '0;
        bus.req_len    = '0;
        bus.req_vc     = '0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        bus.credit_in  = '0;
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b0;
        repeat (3) tick();
        // reset state
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_data_ready", bus.data_ready, 0);
        chk("rst_flit_wr", bus.flit_wr, 0);
        chk("rst_flit_out", bus.flit_out, 0);
        chk("rst_flit_vc", bus.flit_vc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_credit_err", credit_err, 0);
        reset = 1'b1;
        repeat (2) tick();

        // single-flit packet
        clear_cap();
        send_req(5, 1, 0);
        tick();
        chk("hdr_latency", bus.flit_wr, 1);
        chk("single_busy_after", busy, 0);
        tick();
        chk_cap("single", 0, 34'h3_0000_0195, 2'b01);
        restore();

        // 4-flit packet on vc1, credits exhausted, then stalled request
        clear_cap();
        send_req(3, 4, 1);
        feed(32'hA, n);
        feed(32'hB, n);
        feed(32'hC, n);
        wait_flits(4);
        chk_cap("p4_h", 0, 34'h2_0000_0493, 2'b10);
        chk_cap("p4_a", 1, 34'h0_0000_000A, 2'b10);
        chk_cap("p4_b", 2, 34'h0_0000_000B, 2'b10);
        chk_cap("p4_c", 3, 34'h1_0000_000C, 2'b10);
        clear_cap();
        send_req(2, 1, 1);
        repeat (6) tick();
        chk("stall_no_flit", cap_f.size(), 0);
        chk("stall_busy", busy, 1);
        bus.credit_in = 2'b10;
        tick();
        wait_flits(1);
        chk_cap("stall_hdr", 0, 34'h3_0000_0192, 2'b10);
        restore();

        // credit starvation on vc0
        clear_cap();
        send_req(7, 8, 0);
        feed(32'h101, n);
        feed(32'h102, n);
        feed(32'h103, n);
        bus.data_valid = 1'b1;
        bus.data_in    = 32'h104;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("starve_data_ready", bus.data_ready, 0);
        end
        chk("starve_flits", cap_f.size(), 4);
        bus.credit_in = 2'b01;
        feed(32'h104, n);
        chk("resume_ticks", n, 2);
        restore();
        feed(32'h105, n);
        feed(32'h106, n);
        feed(32'h107, n);
        wait_flits(8);
        chk_cap("starve_w4", 4, 34'h0_0000_0104, 2'b01);
        chk_cap("starve_tail", 7, 34'h1_0000_0107, 2'b01);
        restore();

        // data_valid gaps
        clear_cap();
        send_req(4, 3, 1);
        feed(32'h11, n);
        repeat (2) tick();
        feed(32'h22, n);
        wait_flits(3);
        chk_cap("gap_h", 0, 34'h2_0000_0394, 2'b10);
        chk_cap("gap_b1", 1, 34'h0_0000_0011, 2'b10);
        chk_cap("gap_b2", 2, 34'h1_0000_0022, 2'b10);
        tick();
        restore();

        // simultaneous send/return, then overflow return
        send_req(1, 1, 0);
        bus.credit_in = 2'b01;
        tick();
        tick();
        chk("simul_no_err", credit_err, 0);
        bus.credit_in = 2'b01;
        tick();
        tick();
        chk("overflow_err", credit_err, 1);

        // async reset mid-body
        clear_cap();
        send_req(8, 8, 1);
        feed(32'h55, n);
        chk("pre_reset_wr", bus.flit_wr, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_flit_wr", bus.flit_wr, 0);
        chk("arst_flit_vc", bus.flit_vc, 0);
        chk("arst_flit_out", bus.flit_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_req_ready", bus.req_ready, 0);
        chk("arst_data_ready", bus.data_ready, 0);
        chk("arst_credit_err", credit_err, 0);
        idle_inputs();
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        clear_cap();
        send_req(9, 5, 1);
        feed(32'h61, n);
        feed(32'h62, n);
        feed(32'h63, n);
        wait_flits(4);
        chk_cap("post_rst_h", 0, 34'h2_0000_0599, 2'b10);
        restore();
        feed(32'h64, n);
        tick();
        restore();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!bus.req_valid && $urandom_range(3) == 0) begin
                bus.req_valid = 1'b1;
                bus.req_dest  = EAw'($urandom);
                bus.req_len   = LENw'($urandom);
                bus.req_vc    = 1'($urandom_range(V - 1));
            end
            bus.data_valid = ($urandom_range(3) != 0);
            bus.data_in    = $urandom;
            for (int v = 0; v < V; v++)
                if (mcred[v] < B && $urandom_range(2) == 0) bus.credit_in[v] = 1'b1;
            tick();
            if (req_hs) bus.req_valid = 1'b0;
        end

        // drain
        bus.req_valid = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) break;
            bus.data_valid = 1'b1;
            bus.data_in    = $urandom;
            for (int v = 0; v < V; v++)
                if (mcred[v] < B) bus.credit_in[v] = 1'b1;
            tick();
        end
        bus.data_valid = 1'b0;
        chk("drain_idle", busy, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/endpoint_flit_injector.md
Name: endpoint_flit_injector

Overview:
- Endpoint-side transmitter for the NoC local port. It turns packet requests plus a payload data stream into head, body and tail flits.
- It drives the router local input channel (flit + write strobe + VC one-hot) and tracks per-VC credits returned by the router.
- One instance sits between each endpoint core and its router local port; it is the sending counterpart of the router local-port receiver.

Parameters:
- V, 2, number of virtual channels (Vw = max(1, clog2(V))).
- B, 4, flit buffer depth per VC in the router input port; initial credit count.
- EAw, 4, endpoint address width.
- SRC_ADDR, 0, this endpoint's address, inserted in every header.
- LENw, 4, packet-length field width, in flits.
- PYw, 32, flit payload width; must be >= 2*EAw+LENw (checked by elaboration assertion).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  packet request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_dest  in  EAw  destination endpoint address.
- req_len  in  LENw  packet length in flits (1..2^LENw-1; 0 treated as 1).
- req_vc  in  Vw  VC index for whole packet.
- data_valid  in  1  body payload word valid.
- data_ready  out  1  body word consumed when valid&ready.
- data_in  in  PYw  body payload word.
- flit_out  out  PYw+2  {hdr, tail, payload}.
- flit_wr  out  1  flit valid this cycle.
- flit_vc  out  V  one-hot VC of flit_out.
- credit_in  in  V  per-VC credit return pulse (one credit per asserted bit per cycle).
- busy  out  1  packet in progress.
- credit_err  out  1  sticky: credit returned to VC already at B.

Behaviour:
- Reset (reset==0, async) values:
  - req_ready=0, data_ready=0, flit_wr=0, flit_out=0, flit_vc=0, busy=0, credit_err=0.
  - All credit counters = B; FSM = IDLE; len/vc registers = 0.
- FSM:
  - IDLE: req_ready=1. On req_valid, latch dest, len (0->1), vc; go to HEAD.
  - HEAD: when credit[vc]>0, register header flit.
    - payload = {zero-pad, len, SRC_ADDR, dest}, with dest in [EAw-1:0], src in [2EAw-1:EAw], len in [2EAw+LENw-1:2EAw].
    - hdr=1; tail=1 iff len==1.
    - remaining = len-1; go to IDLE if len==1, else BODY.
  - BODY: data_ready = credit[vc]>0. On data_valid&data_ready, register flit {hdr=0, tail=(remaining==1), data_in} and decrement remaining. When remaining hits 0 after the tail flit, go to IDLE.
- Outputs:
  - All flit outputs are registered: flit_wr pulses exactly one cycle per flit.
  - flit_vc is one-hot of the latched vc while flit_wr=1, and 0 otherwise.
- Latency:
  - Header appears the cycle after the cycle following request acceptance (accept in IDLE, HEAD next cycle, flit registered at end of HEAD cycle).
  - One flit per cycle maximum.
- busy=1 in HEAD/BODY.
- Credits:
  - Counter width clog2(B+1).
  - credit[v] decrements on each flit sent on v; increments on credit_in[v].
  - Same-cycle send and return on the same VC: counter unchanged.
  - Return when counter==B and no same-cycle send: counter holds at B and credit_err is set (sticky until reset).
  - Credits on non-active VCs are tracked independently, including while idle.
- Stalls:
  - Zero credits stall HEAD/BODY with flit_wr=0 and data_ready=0.
  - data_valid=0 in BODY stalls with no flit and no bubble penalty.
- A new request is never accepted before the tail is sent; no back-to-back overlap.
- Reset mid-packet aborts the packet immediately. No tail is generated, and the router side must also be reset.

Test Plan:
- Single-flit packet: req dest=5, len=1, vc=0, B=4 -> one flit with hdr=1, tail=1, payload[3:0]=5, payload[11:8]=1; flit_vc=01; credit[0]=3; busy low afterwards.
- 4-flit packet on vc=1 with data 0xA,0xB,0xC, no credit return -> flits in order H, 0xA, 0xB, 0xC(tail=1), all flit_vc=10; credit[1]=0; a following vc=1 request stalls in HEAD with flit_wr=0.
- Credit starvation: B=2, len=4, credits returned after 5 cycles -> exactly 2 flits sent, then flit_wr=0 and data_ready=0 until credit_in[vc]. Transmission resumes the cycle after the return, and no flit is lost or duplicated.
- Simultaneous send and credit return on the same VC in one cycle -> counter unchanged. Extra return with counter=B -> credit_err=1 and counter remains B.
- data_valid gaps: len=3, data_valid toggled 1,0,0,1 -> body flits appear only on valid cycles, tail on the second body word.
- Async reset asserted mid-BODY -> outputs zero immediately without a clock edge. Credits = B after release; the next request produces a fresh header.
